fpu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one FPU datapath among NUM_REQ requesters. The FPU datapath is the float_to_int / int_to_float / adder / multiplier / divider bundle with a 3-bit op select and an exec/done strobe pair. The arbiter grants one requester at a time, latches its op and operands, and drives them to the FPU. It issues a single exec strobe, waits for the done strobe (with an optional timeout), then returns the result to the granted requester. It sits between the CPU/rasterizer-side clients and the FPU wrapper.

---
 rtl/fpu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_fpu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpu_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one FPU among NUM_REQ
//            requesters: grant, issue, wait for done (or timeout), respond.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [3*NUM_REQ-1:0]    req_op_i,
  input  logic [32*NUM_REQ-1:0]   req_a_i,
  input  logic [32*NUM_REQ-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [NUM_REQ-1:0]      resp_valid_o,
  output logic [31:0]             resp_value_o,
  output logic                    resp_error_o,
  output logic                    busy_o,
  output logic [2:0]              fpu_op_o,
  output logic [31:0]             fpu_a_o,
  output logic [31:0]             fpu_b_o,
  output logic                    fpu_exec_strobe_o,
  input  logic [31:0]             fpu_z_i,
  input  logic                    fpu_done_strobe_i
);

  localparam int c_IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_IW:0]   c_NUM   = (c_IW+1)'(NUM_REQ);
  localparam logic [c_IW-1:0] c_LAST  = c_IW'(NUM_REQ - 1);
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_IW-1:0] r_rr_ptr;
  logic [c_IW-1:0] r_grant;
  logic [c_TW-1:0] r_tcnt;
  logic [2:0]      r_fpu_op;
  logic [31:0]     r_fpu_a;
  logic [31:0]     r_fpu_b;
  logic [31:0]     r_resp_value;
  logic            r_resp_error;

  logic [2:0]      w_op [NUM_REQ];
  logic [31:0]     w_a  [NUM_REQ];
  logic [31:0]     w_b  [NUM_REQ];
  logic            w_any;
  logic [c_IW-1:0] w_sel;
  logic            w_accept;
  logic            w_legal;
  logic            w_timeout;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_op[gi] = req_op_i[3*gi +: 3];
    assign w_a[gi]  = req_a_i[32*gi +: 32];
    assign w_b[gi]  = req_b_i[32*gi +: 32];
  end

  // Scan downward so the closest valid index at/after the pointer wins last.
  always_comb begin
    logic [c_IW:0] v_sum;
    logic [c_IW:0] v_idx;
    w_any = 1'b0;
    w_sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_sum = {1'b0, r_rr_ptr} + (c_IW+1)'(k);
      v_idx = (v_sum >= c_NUM) ? (v_sum - c_NUM) : v_sum;
      if (req_valid_i[v_idx[c_IW-1:0]]) begin
        w_any = 1'b1;
        w_sel = v_idx[c_IW-1:0];
      end
    end
  end

  assign w_accept  = (r_state == c_IDLE) && w_any;
  assign w_legal   = (w_op[w_sel] <= 3'd4);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_tcnt == c_TLAST);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) r_state <= c_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = w_legal ? c_ISSUE : c_RESP;
      c_ISSUE: w_state_nxt = c_WAIT;
      c_WAIT:  if (fpu_done_strobe_i || w_timeout) w_state_nxt = c_RESP;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Ready is masked by reset so no client sees an accept while reset is held.
  always_comb begin
    req_ready_o       = '0;
    resp_valid_o      = '0;
    fpu_exec_strobe_o = 1'b0;
    busy_o            = (r_state != c_IDLE);
    case (r_state)
      c_IDLE:  if (w_any && !reset_i) req_ready_o[w_sel] = 1'b1;
      c_ISSUE: fpu_exec_strobe_o = 1'b1;
      c_RESP:  resp_valid_o[r_grant] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_tcnt       <= '0;
      r_fpu_op     <= '0;
      r_fpu_a      <= '0;
      r_fpu_b      <= '0;
      r_resp_value <= '0;
      r_resp_error <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_fpu_op <= w_op[w_sel];
            r_fpu_a  <= w_a[w_sel];
            r_fpu_b  <= w_b[w_sel];
            r_grant  <= w_sel;
            if (!w_legal) begin
              r_resp_value <= '0;
              r_resp_error <= 1'b1;
            end
          end
        end
        c_ISSUE: r_tcnt <= '0;
        c_WAIT: begin
          // Done takes priority over a timeout expiring in the same cycle.
          if (fpu_done_strobe_i) begin
            r_resp_value <= fpu_z_i;
            r_resp_error <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
            if (w_timeout) begin
              r_resp_value <= '0;
              r_resp_error <= 1'b1;
            end
          end
        end
        default: r_rr_ptr <= (r_grant == c_LAST) ? '0 : r_grant + 1'b1;
      endcase
    end
  end

  assign fpu_op_o     = r_fpu_op;
  assign fpu_a_o      = r_fpu_a;
  assign fpu_b_o      = r_fpu_b;
  assign resp_value_o = r_resp_value;
  assign resp_error_o = r_resp_error;

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fpu_arbiter
// Purpose  : Self-checking bench for fpu_arbiter with a stub FPU and a
//            transaction-level round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    vld;
  logic [2:0]      top [N];
  logic [31:0]     ta  [N];
  logic [31:0]     tbv [N];
  int              tlat[N];
  logic [3*N-1:0]  req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;

  always_comb begin
    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    for (int i = 0; i < N; i++) begin
      req_op[3*i +: 3]  = top[i];
      req_a[32*i +: 32] = ta[i];
      req_b[32*i +: 32] = tbv[i];
    end
  end

  logic [N-1:0] req_ready_o, resp_valid_o;
  logic [31:0]  resp_value_o, fpu_a_o, fpu_b_o, fpu_z;
  logic         resp_error_o, busy_o, fpu_exec_strobe_o, fpu_done, inj_done;
  logic [2:0]   fpu_op_o;

  fpu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_i(reset_i),
    .req_valid_i(vld), .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o),
    .resp_value_o(resp_value_o), .resp_error_o(resp_error_o), .busy_o(busy_o),
    .fpu_op_o(fpu_op_o), .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o),
    .fpu_exec_strobe_o(fpu_exec_strobe_o), .fpu_z_i(fpu_z),
    .fpu_done_strobe_i(fpu_done | inj_done)
  );

  int checks = 0;
  int errors = 0;
  int model_rr = 0;
  int resp_cnt = 0;
  int stub_lat = 1;
  int stub_cnt;

  function automatic logic [31:0] fpu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'd2 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (op == 3'd3 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (op == 3'd1 && a == 32'd5) return 32'h40A0_0000;
    return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]} ^ {29'd0, op};
  endfunction

  // Stub FPU: done arrives on the stub_lat-th cycle after exec (0 = never);
  // fpu_z carries noise except in the done cycle.
  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      fpu_done <= 1'b0;
      fpu_z    <= '0;
      stub_cnt <= 0;
    end else begin
      fpu_done <= 1'b0;
      fpu_z    <= $urandom;
      if (fpu_exec_strobe_o) begin
        if (stub_lat == 1) begin
          fpu_done <= 1'b1;
          fpu_z    <= fpu_fn(fpu_op_o, fpu_a_o, fpu_b_o);
          stub_cnt <= 0;
        end else begin
          stub_cnt <= (stub_lat > 1) ? stub_lat - 1 : 0;
        end
      end else if (stub_cnt == 1) begin
        fpu_done <= 1'b1;
        fpu_z    <= fpu_fn(fpu_op_o, fpu_a_o, fpu_b_o);
        stub_cnt <= 0;
      end else if (stub_cnt > 1) begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  always @(negedge clk) if (resp_valid_o != '0) resp_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic int rand_lat();
    return ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
  endfunction

  // One full transaction starting in an IDLE cycle; grant predicted by the model.
  task automatic do_txn(input bit drop, output int g);
    logic [2:0]  op;
    logic [31:0] a, b, exp_v;
    int lat, exp_cyc, exp_ex, cyc, ex;
    bit exp_e, ready_busy;
    g = pick(vld, model_rr);
    if (g < 0) begin
      check("grant_exists", 32'd0, 32'd1);
      return;
    end
    op = top[g]; a = ta[g]; b = tbv[g]; lat = tlat[g];
    stub_lat = lat;
    if (op > 3'd4) begin
      exp_cyc = 1; exp_ex = 0; exp_e = 1'b1; exp_v = '0;
    end else if (lat >= 1 && lat <= TMO) begin
      exp_cyc = lat + 2; exp_ex = 1; exp_e = 1'b0; exp_v = fpu_fn(op, a, b);
    end else begin
      exp_cyc = TMO + 2; exp_ex = 1; exp_e = 1'b1; exp_v = '0;
    end
    #1;
    check("ready_onehot", 32'(req_ready_o), 32'(1) << g);
    cyc = 0; ex = 0; ready_busy = 1'b0;
    do begin
      step();
      cyc++;
      if (cyc == 1) begin
        check("fpu_op_latched", 32'(fpu_op_o), 32'(op));
        check("fpu_a_latched", fpu_a_o, a);
        check("fpu_b_latched", fpu_b_o, b);
        check("busy_after_accept", 32'(busy_o), 32'd1);
        top[g]  = 3'($urandom_range(0, 7));
        ta[g]   = $urandom;
        tbv[g]  = $urandom;
        tlat[g] = rand_lat();
      end
      if (fpu_exec_strobe_o) ex++;
      if (req_ready_o != '0) ready_busy = 1'b1;
    end while (resp_valid_o == '0 && cyc < 40);
    check("resp_latency", 32'(cyc), 32'(exp_cyc));
    check("resp_valid_onehot", 32'(resp_valid_o), 32'(1) << g);
    check("resp_value", resp_value_o, exp_v);
    check("resp_error", 32'(resp_error_o), 32'(exp_e));
    check("exec_pulses", 32'(ex), 32'(exp_ex));
    check("no_ready_while_busy", 32'(ready_busy), 32'd0);
    check("fpu_op_held", 32'(fpu_op_o), 32'(op));
    check("fpu_a_held", fpu_a_o, a);
    if (drop) vld[g] = 1'b0;
    model_rr = (g + 1) % N;
    step();
    check("idle_after_resp", 32'(busy_o), 32'd0);
    check("resp_valid_single", 32'(resp_valid_o), 32'd0);
    check("resp_value_hold", resp_value_o, exp_v);
  endtask

  initial begin
    int g, n;
    inj_done = 1'b0;
    vld = '1;
    for (int i = 0; i < N; i++) begin
      top[i] = 3'd2; ta[i] = 32'h1234_5678; tbv[i] = 32'h9ABC_DEF0; tlat[i] = 1;
    end
    #1;
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_exec", 32'(fpu_exec_strobe_o), 32'd0);
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_fpu_op", 32'(fpu_op_o), 32'd0);
    check("rst_resp_value", resp_value_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    vld = '0;
    step();

    // Requester 1 add
    top[1] = 3'd2; ta[1] = 32'h3F80_0000; tbv[1] = 32'h4000_0000; tlat[1] = 3;
    vld[1] = 1'b1;
    do_txn(1'b1, g);
    check("add_grant", 32'(g), 32'd1);

    // Requester 3 mul then i2f
    top[3] = 3'd3; ta[3] = 32'h4000_0000; tbv[3] = 32'h4040_0000; tlat[3] = 5;
    vld[3] = 1'b1;
    do_txn(1'b0, g);
    top[3] = 3'd1; ta[3] = 32'd5; tbv[3] = 32'd0; tlat[3] = 1;
    do_txn(1'b1, g);
    check("i2f_grant", 32'(g), 32'd3);

    // All valid continuously: strict rotation
    for (int i = 0; i < N; i++) begin
      top[i] = 3'($urandom_range(0, 4)); ta[i] = $urandom; tbv[i] = $urandom;
      tlat[i] = int'($urandom_range(1, 6));
    end
    vld = '1;
    for (int i = 0; i < 5; i++) begin
      do_txn(1'b0, g);
      check("rr_order", 32'(g), 32'(i % N));
    end
    vld = '0;

    // Illegal op
    top[2] = 3'd7; ta[2] = $urandom; tbv[2] = $urandom; tlat[2] = 1;
    vld[2] = 1'b1;
    do_txn(1'b1, g);

    // Timeout, then done exactly on the last WAIT cycle, then one earlier
    top[0] = 3'd2; ta[0] = 32'hDEAD_0001; tbv[0] = 32'h0BAD_F00D; tlat[0] = 0;
    vld[0] = 1'b1;
    do_txn(1'b1, g);
    top[0] = 3'd4; ta[0] = 32'hCAFE_0002; tbv[0] = 32'h0000_1111; tlat[0] = TMO;
    vld[0] = 1'b1;
    do_txn(1'b1, g);
    top[0] = 3'd0; ta[0] = 32'h4100_0000; tbv[0] = 32'h0; tlat[0] = TMO - 1;
    vld[0] = 1'b1;
    do_txn(1'b1, g);

    // Stray done while idle is ignored
    n = resp_cnt;
    inj_done = 1'b1;
    step();
    check("stray_done_busy", 32'(busy_o), 32'd0);
    inj_done = 1'b0;
    step();
    check("stray_done_no_resp", 32'(resp_cnt), 32'(n));

    // Move the pointer to 2, then reset during WAIT
    top[1] = 3'd2; ta[1] = 32'h3F80_0000; tbv[1] = 32'h4000_0000; tlat[1] = 2;
    vld[1] = 1'b1;
    do_txn(1'b1, g);
    top[2] = 3'd3; ta[2] = 32'h1111_2222; tbv[2] = 32'h3333_4444; tlat[2] = 0;
    stub_lat = 0;
    vld[2] = 1'b1;
    #1;
    check("pre_rst_ready", 32'(req_ready_o), 32'b0100);
    step();
    vld = '0;
    step();
    step();
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    n = resp_cnt;
    #2;
    vld = 4'b1001;
    reset_i = 1'b1;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_ready", 32'(req_ready_o), 32'd0);
    check("arst_fpu_op", 32'(fpu_op_o), 32'd0);
    check("arst_fpu_a", fpu_a_o, 32'd0);
    check("arst_resp_value", resp_value_o, 32'd0);
    step();
    step();
    reset_i = 1'b0;
    model_rr = 0;
    top[0] = 3'd2; ta[0] = 32'h3F80_0000; tbv[0] = 32'h4000_0000; tlat[0] = 4;
    top[3] = 3'd1; ta[3] = 32'd5; tbv[3] = 32'd0; tlat[3] = 2;
    check("arst_no_resp", 32'(resp_cnt), 32'(n));
    do_txn(1'b1, g);
    check("post_rst_grant", 32'(g), 32'd0);
    do_txn(1'b1, g);

    // Randomized traffic with a pending set per requester
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 1) == 1) begin
          top[i] = 3'($urandom_range(0, 7)); ta[i] = $urandom; tbv[i] = $urandom;
          tlat[i] = rand_lat();
          vld[i] = 1'b1;
        end
      end
      if (vld == '0) begin
        top[0] = 3'($urandom_range(0, 4)); ta[0] = $urandom; tbv[0] = $urandom;
        tlat[0] = int'($urandom_range(1, TMO));
        vld[0] = 1'b1;
      end
      do_txn(1'b1, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
